// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyph codes (a..g, h=DP) and the
// scan-reader state type.
package seg7_pkg;

  localparam logic [7:0] SEG7_PAT_0 = 8'h03;
  localparam logic [7:0] SEG7_PAT_1 = 8'h9F;
  localparam logic [7:0] SEG7_PAT_2 = 8'h25;
  localparam logic [7:0] SEG7_PAT_3 = 8'h0D;
  localparam logic [7:0] SEG7_PAT_4 = 8'h99;
  localparam logic [7:0] SEG7_PAT_5 = 8'h49;
  localparam logic [7:0] SEG7_PAT_6 = 8'h41;
  localparam logic [7:0] SEG7_PAT_7 = 8'h1F;
  localparam logic [7:0] SEG7_PAT_8 = 8'h01;
  localparam logic [7:0] SEG7_PAT_9 = 8'h09;
  localparam logic [7:0] SEG7_PAT_A = 8'h11;
  localparam logic [7:0] SEG7_PAT_B = 8'hC1;
  localparam logic [7:0] SEG7_PAT_C = 8'h63;
  localparam logic [7:0] SEG7_PAT_D = 8'h85;
  localparam logic [7:0] SEG7_PAT_E = 8'h61;
  localparam logic [7:0] SEG7_PAT_F = 8'h71;
  localparam logic [7:0] SEG7_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

endpackage

// File: rtl/seg7_pat_dec.sv
// Combinational decode of a 7-bit active-low abcdefg pattern to a hex value,
// flagging legal glyphs (hit) and the all-off pattern (blank).
module seg7_pat_dec
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic       blank,
  output logic [3:0] hex
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hit = 1'b1;
    hex = 4'h0;
    case (pat)
      SEG7_PAT_0[7:1]: hex = 4'h0;
      SEG7_PAT_1[7:1]: hex = 4'h1;
      SEG7_PAT_2[7:1]: hex = 4'h2;
      SEG7_PAT_3[7:1]: hex = 4'h3;
      SEG7_PAT_4[7:1]: hex = 4'h4;
      SEG7_PAT_5[7:1]: hex = 4'h5;
      SEG7_PAT_6[7:1]: hex = 4'h6;
      SEG7_PAT_7[7:1]: hex = 4'h7;
      SEG7_PAT_8[7:1]: hex = 4'h8;
      SEG7_PAT_9[7:1]: hex = 4'h9;
      SEG7_PAT_A[7:1]: hex = 4'hA;
      SEG7_PAT_B[7:1]: hex = 4'hB;
      SEG7_PAT_C[7:1]: hex = 4'hC;
      SEG7_PAT_D[7:1]: hex = 4'hD;
      SEG7_PAT_E[7:1]: hex = 4'hE;
      SEG7_PAT_F[7:1]: hex = 4'hF;
      default:         hit = 1'b0;
    endcase
    blank = (pat == SEG7_BLANK[7:1]);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scanned 7-segment bus reader: captures each digit once per stable episode.
// Define SEG7_DEC_ERRCNT_EN to add the saturating illegal-capture counter oERR_CNT.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIG        = 4,
  parameter int STABLE_CYC     = 4,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [7:0]           iSEG,
  input  logic [NUM_DIG-1:0]   iSEL,
  input  logic                 iERR_CLR,
  output logic [4*NUM_DIG-1:0] oDIG,
  output logic [NUM_DIG-1:0]   oDP,
  output logic [NUM_DIG-1:0]   oVALID,
  output logic                 oUPD,
  output logic [2:0]           oUPD_IDX,
  output logic                 oERR
`ifdef SEG7_DEC_ERRCNT_EN
  ,
  output logic [7:0]           oERR_CNT
`endif
);

  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYC);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYC - 1);

  logic [7:0]         seg_q;
  logic [NUM_DIG-1:0] sel_q;
  logic [7:0]         stable_cnt;
  state_t             state;

  logic               changed;
  logic               in_onehot;
  logic               capture;
  logic               illegal;
  logic [NUM_DIG-1:0] sel_en;
  logic [NUM_DIG-1:0] sel_en_q;
  logic [2:0]         cap_idx;
  logic               pat_hit;
  logic               pat_blank;
  logic [3:0]         pat_hex;

  assign changed   = ({iSEG, iSEL} != {seg_q, sel_q});
  assign sel_en    = (SEL_ACTIVE_LOW != 0) ? ~iSEL  : iSEL;
  assign sel_en_q  = (SEL_ACTIVE_LOW != 0) ? ~sel_q : sel_q;
  assign in_onehot = $onehot(sel_en);
  assign capture   = !changed && (state == SETTLE) && (stable_cnt == CNT_CAP);
  assign illegal   = capture && !pat_hit && !pat_blank;

  always_comb begin
    cap_idx = 3'd0;
    for (int i = 0; i < NUM_DIG; i++)
      if (sel_en_q[i]) cap_idx = 3'(i);
  end

  seg7_pat_dec u_pat_dec (
    .pat   (seg_q[7:1]),
    .hit   (pat_hit),
    .blank (pat_blank),
    .hex   (pat_hex)
  );

  // Samples reset to zero, so whatever is on the bus after reset reads as a change.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      seg_q      <= '0;
      sel_q      <= '0;
      stable_cnt <= '0;
      state      <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values regardless of statement order.
      seg_q <= iSEG;
      sel_q <= iSEL;
      if (changed) begin
        stable_cnt <= '0;
        state      <= in_onehot ? SETTLE : IDLE;
      end else begin
        if (stable_cnt != CNT_SAT) stable_cnt <= stable_cnt + 8'd1;
        if (capture)               state      <= HELD;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDIG     <= '0;
      oDP      <= '0;
      oVALID   <= '0;
      oUPD     <= 1'b0;
      oUPD_IDX <= '0;
      oERR     <= 1'b0;
    end else begin
      oUPD <= capture;
      if (capture) oUPD_IDX <= cap_idx;
      for (int i = 0; i < NUM_DIG; i++) begin
        if (capture && sel_en_q[i]) begin
          oDP[i]    <= ~seg_q[0];
          oVALID[i] <= pat_hit;
          if (pat_hit) oDIG[4*i +: 4] <= pat_hex;
        end
      end
      // Later assignment wins: an illegal capture overrides a same-cycle clear.
      if (iERR_CLR) oERR <= 1'b0;
      if (illegal)  oERR <= 1'b1;
    end
  end

`ifdef SEG7_DEC_ERRCNT_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oERR_CNT <= '0;
    end else if (illegal) begin
      if (iERR_CLR)               oERR_CNT <= 8'd1;
      else if (oERR_CNT != 8'hFF) oERR_CNT <= oERR_CNT + 8'd1;
    end else if (iERR_CLR) begin
      oERR_CNT <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes expected captures,
// a negedge monitor pops and compares them on every oUPD pulse.
module tb_seg7_scan_decoder;

  localparam int NUM_DIG    = 4;
  localparam int STABLE_CYC = 4;

  logic                 iCLK = 1'b0;
  logic                 iRST = 1'b0;
  logic [7:0]           iSEG = 8'hFF;
  logic [NUM_DIG-1:0]   iSEL = '1;
  logic                 iERR_CLR = 1'b0;
  logic [4*NUM_DIG-1:0] oDIG;
  logic [NUM_DIG-1:0]   oDP;
  logic [NUM_DIG-1:0]   oVALID;
  logic                 oUPD;
  logic [2:0]           oUPD_IDX;
  logic                 oERR;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0]           oERR_CNT;
`endif

  seg7_scan_decoder #(
    .NUM_DIG        (NUM_DIG),
    .STABLE_CYC     (STABLE_CYC),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iSEG     (iSEG),
    .iSEL     (iSEL),
    .iERR_CLR (iERR_CLR),
    .oDIG     (oDIG),
    .oDP      (oDP),
    .oVALID   (oVALID),
    .oUPD     (oUPD),
    .oUPD_IDX (oUPD_IDX),
    .oERR     (oERR)
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    .oERR_CNT (oERR_CNT)
`endif
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic [15:0] dig;
    logic [3:0]  valid;
    logic [3:0]  dp;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic put(input logic [7:0] s, input logic [3:0] sel);
    iSEG = s;
    iSEL = sel;
  endtask

  // Call in the cycle the new inputs are driven: capture lands STABLE_CYC edges
  // after the first sampling edge, seen on the following negedge.
  task automatic expect_cap(input logic [2:0] idx, input logic [15:0] dig,
                            input logic [3:0] valid, input logic [3:0] dp, input logic err);
    exp_t e;
    e.cyc = cyc + STABLE_CYC + 1;
    e.idx = idx; e.dig = dig; e.valid = valid; e.dp = dp; e.err = err;
    sb.push_back(e);
  endtask

  always @(negedge iCLK) begin : monitor
    exp_t e;
    if (!iRST) begin
      if (oUPD) begin
        if (sb.size() == 0) begin
          check("unexpected_upd", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("upd_cycle", cyc, e.cyc);
          check("upd_idx", 32'(oUPD_IDX), 32'(e.idx));
          check("dig", 32'(oDIG), 32'(e.dig));
          check("valid", 32'(oVALID), 32'(e.valid));
          check("dp", 32'(oDP), 32'(e.dp));
          check("err", 32'(oERR), 32'(e.err));
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missed_upd", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 iRST = 1'b1;
    #2;
    check("reset_outs", 32'({oDIG, oDP, oVALID, oUPD, oUPD_IDX, oERR}), 32'd0);
    step(); step();
    iRST = 1'b0;
    repeat (3) step();

    // Digit 0 shows "3", DP off.
    put(8'h0D, 4'b1110);
    expect_cap(3'd0, 16'h0003, 4'b0001, 4'b0000, 1'b0);
    repeat (6) step();

    // Digit 3 shows "8" with DP lit.
    put(8'h00, 4'b0111);
    expect_cap(3'd3, 16'h8003, 4'b1001, 4'b1000, 1'b0);
    repeat (6) step();

    // Glitch: "3" for two cycles, then "2" holds; only "2" is captured.
    put(8'h0D, 4'b1101);
    step(); step();
    put(8'h25, 4'b1101);
    expect_cap(3'd1, 16'h8023, 4'b1011, 4'b1000, 1'b0);
    repeat (6) step();

    // Illegal glyph on digit 1: valid cleared, digit kept, error raised.
    put(8'hFD, 4'b1101);
    expect_cap(3'd1, 16'h8023, 4'b1001, 4'b1000, 1'b1);
    repeat (6) step();

    // Blank on digit 1: still invalid, error stays.
    put(8'hFF, 4'b1101);
    expect_cap(3'd1, 16'h8023, 4'b1001, 4'b1000, 1'b1);
    repeat (6) step();

    // Blank with DP lit on digit 2: not an error, DP recorded.
    put(8'hFE, 4'b1011);
    expect_cap(3'd2, 16'h8023, 4'b1001, 4'b1100, 1'b1);
    repeat (6) step();

    iERR_CLR = 1'b1;
    step();
    iERR_CLR = 1'b0;
    check("err_cleared", 32'(oERR), 32'd0);

    // Illegal capture coinciding with a clear: set wins.
    put(8'hFD, 4'b1110);
    expect_cap(3'd0, 16'h8023, 4'b1000, 4'b1100, 1'b1);
    repeat (4) step();
    iERR_CLR = 1'b1;
    step();
    iERR_CLR = 1'b0;
    step();
    check("err_set_wins", 32'(oERR), 32'd1);

    iERR_CLR = 1'b1;
    step();
    iERR_CLR = 1'b0;

    // Non-one-hot selects never capture or flag.
    put(8'h03, 4'b1111);
    repeat (10) step();
    put(8'h03, 4'b0011);
    repeat (10) step();
    check("no_err_nonhot", 32'(oERR), 32'd0);
    check("no_upd_nonhot", 32'(oUPD), 32'd0);

    // Reset while settling.
    put(8'h9F, 4'b1110);
    step(); step();
    iRST = 1'b1;
    #1;
    check("rst_settle_outs", 32'({oDIG, oDP, oVALID, oUPD, oUPD_IDX, oERR}), 32'd0);
    step();
    iRST = 1'b0;
    expect_cap(3'd0, 16'h0001, 4'b0001, 4'b0000, 1'b0);
    repeat (8) step();

    // Reset while held.
    iRST = 1'b1;
    #1;
    check("rst_held_outs", 32'({oDIG, oDP, oVALID, oUPD, oUPD_IDX, oERR}), 32'd0);
    step();
    iRST = 1'b0;
    expect_cap(3'd0, 16'h0001, 4'b0001, 4'b0000, 1'b0);
    repeat (8) step();

`ifdef SEG7_DEC_ERRCNT_EN
    check("errcnt_start", 32'(oERR_CNT), 32'd0);
    for (int i = 0; i < 300; i++) begin
      put((i % 2 == 0) ? 8'hFD : 8'hFB, 4'b1110);
      expect_cap(3'd0, 16'h0001, 4'b0000, 4'b0000, 1'b1);
      repeat (5) step();
    end
    check("errcnt_sat", 32'(oERR_CNT), 32'd255);

    put(8'hFD, 4'b1110);
    expect_cap(3'd0, 16'h0001, 4'b0000, 4'b0000, 1'b1);
    repeat (4) step();
    iERR_CLR = 1'b1;
    step();
    iERR_CLR = 1'b0;
    check("errcnt_clr_inc", 32'(oERR_CNT), 32'd1);
    step();
    iERR_CLR = 1'b1;
    step();
    iERR_CLR = 1'b0;
    check("errcnt_clr", 32'(oERR_CNT), 32'd0);
    check("err_after_clr", 32'(oERR), 32'd0);
`endif

    repeat (10) step();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
